// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional MADD/MSUB accumulate ops are built only when MD_UNIT_MADD_EN is defined.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             md_stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic               w_long;
    logic               w_is_div;
    logic               w_accept;
    logic               w_commit;
    logic               w_wr;
    logic [2*WIDTH-1:0] w_res;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;

    // Signed divide via magnitudes so most-negative / -1 wraps to most-negative with zero remainder.
    function automatic logic [2*WIDTH-1:0] sdivrem(input logic [WIDTH-1:0] n,
                                                   input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] nm, dm, q, r;
        nm = n[WIDTH-1] ? -n : n;
        dm = d[WIDTH-1] ? -d : d;
        q  = nm / dm;
        r  = nm % dm;
        if (n[WIDTH-1] ^ d[WIDTH-1]) q = -q;
        if (n[WIDTH-1]) r = -r;
        return {r, q};
    endfunction

    // Classify the incoming op as long (multi-cycle) and pick its latency class.
    always_comb begin
        w_long   = 1'b0;
        w_is_div = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: w_long = 1'b1;
            OP_DIV, OP_DIVU: begin
                w_long   = 1'b1;
                w_is_div = 1'b1;
            end
`ifdef MD_UNIT_MADD_EN
            OP_MADD, OP_MSUB: w_long = 1'b1;
`endif
            default: begin
                w_long   = 1'b0;
                w_is_div = 1'b0;
            end
        endcase
    end

    assign w_accept = start & ~r_busy;
    assign w_commit = r_busy & (r_cnt == CNT_ONE);
    assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    // Result computed from latched operands on the commit edge; accumulate sees commit-time HI/LO.
    always_comb begin
        w_wr  = 1'b0;
        w_res = {r_hi, r_lo};
        if (w_commit) begin
            case (r_op)
                OP_MULT: begin
                    w_wr  = 1'b1;
                    w_res = w_prod_s;
                end
                OP_MULTU: begin
                    w_wr  = 1'b1;
                    w_res = w_prod_u;
                end
                OP_DIV: begin
                    w_wr  = (r_b != '0);
                    w_res = sdivrem(r_a, r_b);
                end
                OP_DIVU: begin
                    w_wr  = (r_b != '0);
                    w_res = {r_a % r_b, r_a / r_b};
                end
`ifdef MD_UNIT_MADD_EN
                OP_MADD: begin
                    w_wr  = 1'b1;
                    w_res = {r_hi, r_lo} + w_prod_s;
                end
                OP_MSUB: begin
                    w_wr  = 1'b1;
                    w_res = {r_hi, r_lo} - w_prod_s;
                end
`endif
                default: begin
                    w_wr  = 1'b0;
                    w_res = {r_hi, r_lo};
                end
            endcase
        end else begin
            w_wr  = 1'b0;
            w_res = {r_hi, r_lo};
        end
    end

    // Operation sequencing: latch operands on acceptance, count down while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_op   <= 3'd0;
            r_a    <= '0;
            r_b    <= '0;
        end else if (w_accept && w_long) begin
            r_busy <= 1'b1;
            r_cnt  <= w_is_div ? DIV_LOAD : MULT_LOAD;
            r_op   <= op;
            r_a    <= a;
            r_b    <= b;
        end else if (r_busy) begin
            r_cnt  <= r_cnt - CNT_ONE;
            r_busy <= (r_cnt != CNT_ONE);
        end else begin
            r_cnt  <= r_cnt;
        end
    end

    // HI/LO: long-op commit or zero-latency MTHI/MTLO (mutually exclusive by busy).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_wr) begin
            {r_hi, r_lo} <= w_res;
        end else if (w_accept && (op == OP_MTHI)) begin
            r_hi <= a;
        end else if (w_accept && (op == OP_MTLO)) begin
            r_lo <= a;
        end else begin
            r_hi <= r_hi;
        end
    end

    assign busy     = r_busy;
    assign md_stall = r_busy | (start & w_long);
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against an arithmetic reference model.
// Directed test-plan scenarios run first; MADD/MSUB checks follow MD_UNIT_MADD_EN.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, md_stall;
    logic [31:0] hi, lo;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: commit scheduled on an absolute edge index.
    logic [31:0] m_hi, m_lo, m_a, m_b;
    logic [2:0]  m_op;
    bit          m_pending;
    int          m_edge, m_commit_edge;

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_long(input logic [2:0] o);
`ifdef MD_UNIT_MADD_EN
        return (o <= 3'd3) || (o >= 3'd6);
`else
        return (o <= 3'd3);
`endif
    endfunction

    task automatic model_apply();
        longint sa, sb, p;
        logic [63:0] acc;
        sa = longint'($signed(m_a));
        sb = longint'($signed(m_b));
        p  = sa * sb;
        acc = {m_hi, m_lo};
        case (m_op)
            3'd0: acc = 64'(p);
            3'd1: acc = 64'(m_a) * 64'(m_b);
            3'd2: if (m_b != 32'd0) acc = {32'(sa % sb), 32'(sa / sb)};
            3'd3: if (m_b != 32'd0) acc = {m_a % m_b, m_a / m_b};
            3'd6: acc = acc + 64'(p);
            3'd7: acc = acc - 64'(p);
            default: ;
        endcase
        {m_hi, m_lo} = acc;
    endtask

    task automatic model_step(input logic rs, input logic st, input logic [2:0] o,
                              input logic [31:0] av, input logic [31:0] bv);
        m_edge++;
        if (rs) begin
            m_hi = 32'd0; m_lo = 32'd0; m_pending = 1'b0;
        end else if (m_pending) begin
            if (m_edge == m_commit_edge) begin
                model_apply();
                m_pending = 1'b0;
            end
        end else if (st) begin
            if (is_long(o)) begin
                m_pending = 1'b1;
                m_commit_edge = m_edge + (((o == 3'd2) || (o == 3'd3)) ? 10 : 5);
                m_op = o; m_a = av; m_b = bv;
            end else if (o == 3'd4) begin
                m_hi = av;
            end else if (o == 3'd5) begin
                m_lo = av;
            end
        end
    endtask

    // One clock: drive inputs away from the edge, check stall, step model, check state after edge.
    task automatic drive(input logic rs, input logic st, input logic [2:0] o,
                         input logic [31:0] av, input logic [31:0] bv);
        reset = rs; start = st; op = o; a = av; b = bv;
        #1;
        check_eq("md_stall", 64'(md_stall), 64'(m_pending | (st & is_long(o))));
        model_step(rs, st, o, av, bv);
        @(posedge clk);
        #1;
        check_eq("busy", 64'(busy), 64'(m_pending));
        check_eq("hi", 64'(hi), 64'(m_hi));
        check_eq("lo", 64'(lo), 64'(m_lo));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        m_hi = 32'd0; m_lo = 32'd0; m_a = 32'd0; m_b = 32'd0; m_op = 3'd0;
        m_pending = 1'b0; m_edge = 0; m_commit_edge = 0;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        check_eq("rst_hi", 64'(hi), 64'h0);
        check_eq("rst_busy", 64'(busy), 64'h0);

        // MULT -2 * 3
        drive(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3);
        idle(4);
        check_eq("mult_busy_last", 64'(busy), 64'h1);
        idle(1);
        check_eq("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check_eq("mult_lo", 64'(lo), 64'hFFFF_FFFA);
        check_eq("mult_done", 64'(busy), 64'h0);

        // DIV -7/2, DIVU 7/2
        drive(1'b0, 1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2);
        idle(9);
        check_eq("div_busy_last", 64'(busy), 64'h1);
        idle(1);
        check_eq("div_lo", 64'(lo), 64'hFFFF_FFFD);
        check_eq("div_hi", 64'(hi), 64'hFFFF_FFFF);
        drive(1'b0, 1'b1, 3'd3, 32'd7, 32'd2);
        idle(10);
        check_eq("divu_lo", 64'(lo), 64'h3);
        check_eq("divu_hi", 64'(hi), 64'h1);

        // Divide by zero keeps HI/LO
        drive(1'b0, 1'b1, 3'd4, 32'h11, 32'd0);
        drive(1'b0, 1'b1, 3'd5, 32'h22, 32'd0);
        drive(1'b0, 1'b1, 3'd2, 32'd9, 32'd0);
        idle(10);
        check_eq("dz_hi", 64'(hi), 64'h11);
        check_eq("dz_lo", 64'(lo), 64'h22);

        // MULTU with ignored starts while busy
        drive(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(1);
        drive(1'b0, 1'b1, 3'd5, 32'd5, 32'd0);
        drive(1'b0, 1'b1, 3'd0, 32'd3, 32'd3);
        idle(2);
        check_eq("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        check_eq("multu_lo", 64'(lo), 64'h1);

        // Most-negative / -1
        drive(1'b0, 1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(10);
        check_eq("ovf_lo", 64'(lo), 64'h8000_0000);
        check_eq("ovf_hi", 64'(hi), 64'h0);

        // Reset mid-divide aborts
        drive(1'b0, 1'b1, 3'd2, 32'd100, 32'd7);
        idle(3);
        drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        check_eq("abort_busy", 64'(busy), 64'h0);
        check_eq("abort_hi", 64'(hi), 64'h0);
        idle(12);
        check_eq("abort_lo", 64'(lo), 64'h0);

`ifdef MD_UNIT_MADD_EN
        drive(1'b0, 1'b1, 3'd4, 32'd0, 32'd0);
        drive(1'b0, 1'b1, 3'd5, 32'hFFFF_FFFF, 32'd0);
        drive(1'b0, 1'b1, 3'd6, 32'd1, 32'd1);
        idle(5);
        check_eq("madd_hi", 64'(hi), 64'h1);
        check_eq("madd_lo", 64'(lo), 64'h0);
        drive(1'b0, 1'b1, 3'd7, 32'd2, 32'd1);
        idle(5);
        check_eq("msub_hi", 64'(hi), 64'h0);
        check_eq("msub_lo", 64'(lo), 64'hFFFF_FFFE);
`else
        drive(1'b0, 1'b1, 3'd5, 32'h55, 32'd0);
        drive(1'b0, 1'b1, 3'd6, 32'd3, 32'd4);
        check_eq("op6_nop_busy", 64'(busy), 64'h0);
        check_eq("op6_nop_lo", 64'(lo), 64'h55);
`endif

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                  3'($urandom_range(0, 7)), pick(), pick());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
